cpu_icache_arbiter: RTL and testbench

- Shares the single instruction-cache request port between NREQ requesters: port 0 is the instruction fetch unit, port 1 is the debug/boot loader.
- Uses round-robin grant selection with burst locking.
- Keeps an in-order FIFO of requester IDs for outstanding reads, so cache responses (rdata/raddr/rtag/rvalid) are routed back to the requester that issued them.
- Sits between the requesters and the icache. The cache's request/ready/response protocol is unchanged on both sides.

---
 rtl/cpu_icache_arb_pkg.sv | 21 ++
 rtl/cpu_id_fifo.sv | 48 ++++
 rtl/cpu_icache_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cpu_icache_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_icache_arb_pkg.sv
// Shared types for the instruction-cache request arbiter.
// Requester IDs, lock FSM states and the response tag width.
package cpu_icache_arb_pkg;

  typedef logic [1:0] req_id_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int ICACHE_TAG_W = 9;

  function automatic req_id_t next_id(
    input req_id_t id,
    input int      n
  );
    return req_id_t'((int'(id) + 1) % n);
  endfunction

endpackage

// File: rtl/cpu_id_fifo.sv
// Small synchronous FIFO with a visible head entry.
// Pointers carry a wrap bit, so DEPTH must be a power of two.
module cpu_id_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_icache_arbiter.sv
// Round-robin arbiter with burst locking in front of the icache port.
// An in-order ID FIFO steers read responses back to their requester.
module cpu_icache_arbiter
  import cpu_icache_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int OUT_DEPTH   = 4,
  parameter int BURST_BEATS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_request,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ-1:0]         req_burst,
  input  logic [NREQ*32-1:0]      req_address,
  input  logic [NREQ*4-1:0]       req_wstrb,
  input  logic [NREQ*32-1:0]      req_wdata,
  output logic [NREQ-1:0]         rsp_rvalid,
  output logic [31:0]             rsp_rdata,
  output logic [31:0]             rsp_raddr,
  output logic [ICACHE_TAG_W-1:0] rsp_rtag,
  output logic                    icache_request,
  input  logic                    icache_ready,
  output logic                    icache_write,
  output logic                    icache_burst,
  output logic [31:0]             icache_address,
  output logic [3:0]              icache_wstrb,
  output logic [31:0]             icache_wdata,
  input  logic [31:0]             icache_rdata,
  input  logic [31:0]             icache_raddr,
  input  logic [ICACHE_TAG_W-1:0] icache_rtag,
  input  logic                    icache_rvalid,
  output logic                    error_overflow
);

  localparam int BW = $clog2(BURST_BEATS) + 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  arb_state_t     state_q, state_d;
  req_id_t        rr_q, rr_d;
  req_id_t        lock_q, lock_d;
  logic [BW-1:0]  beats_q, beats_d;
  req_id_t        grant;
  logic           sel_req;
  logic           sel_burst;
  logic           accept;
  logic           push;
  logic           pop;
  logic           fifo_block;
  logic           fifo_full;
  logic           fifo_empty;
  req_id_t        fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           unused_count;

  // First requester at or after rr_q wins unless a burst holds the port.
  always_comb begin : grant_sel
    logic found;
    found = 1'b0;
    grant = rr_q;
    if (state_q == ARB_LOCKED) begin
      grant = lock_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_request[i] &&
              ((int'(rr_q) + k) % NREQ) == i) begin
            grant = req_id_t'(i);
            found = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_req        = 1'b0;
    sel_burst      = 1'b0;
    icache_write   = 1'b0;
    icache_address = '0;
    icache_wstrb   = '0;
    icache_wdata   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == req_id_t'(i)) begin
        sel_req        = req_request[i];
        sel_burst      = req_burst[i];
        icache_write   = req_write[i];
        icache_address = req_address[32*i +: 32];
        icache_wstrb   = req_wstrb[4*i +: 4];
        icache_wdata   = req_wdata[32*i +: 32];
      end
    end
  end

  assign icache_burst   = sel_burst;
  assign pop            = !reset && icache_rvalid && !fifo_empty;
  assign fifo_block     = fifo_full && !pop;
  assign icache_request = !reset && sel_req && !fifo_block;
  assign accept         = icache_request && icache_ready;
  assign push           = accept && !icache_write;
  assign error_overflow = !reset && icache_rvalid && fifo_empty;

  always_comb begin
    req_ready  = '0;
    rsp_rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i]  = accept && grant == req_id_t'(i);
      rsp_rvalid[i] = pop && fifo_head == req_id_t'(i);
    end
  end

  assign rsp_rdata = icache_rdata;
  assign rsp_raddr = icache_raddr;
  assign rsp_rtag  = icache_rtag;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    beats_d = beats_q;
    rr_d    = rr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          rr_d = next_id(grant, NREQ);
          if (sel_burst && BURST_BEATS > 1) begin
            state_d = ARB_LOCKED;
            lock_d  = grant;
            beats_d = BW'(BURST_BEATS - 1);
          end
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          beats_d = beats_q - BW'(1);
          if (beats_q == BW'(1)) begin
            state_d = ARB_IDLE;
            rr_d    = next_id(lock_q, NREQ);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      beats_q <= beats_d;
    end
  end

  cpu_id_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH ($bits(req_id_t))
  ) u_id_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_cpu_icache_arbiter.sv
// Directed vector bench for cpu_icache_arbiter (NREQ=2, depth 4,
// four-beat bursts); one table row per clock cycle.
module tb_cpu_icache_arbiter;

  localparam int NREQ = 2;
  localparam logic [31:0] WK = 32'h5a5a_0000;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_request;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_write;
  logic [NREQ-1:0]   req_burst;
  logic [NREQ*32-1:0] req_address;
  logic [NREQ*4-1:0] req_wstrb;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]   rsp_rvalid;
  logic [31:0]       rsp_rdata;
  logic [31:0]       rsp_raddr;
  logic [8:0]        rsp_rtag;
  logic              icache_request;
  logic              icache_ready;
  logic              icache_write;
  logic              icache_burst;
  logic [31:0]       icache_address;
  logic [3:0]        icache_wstrb;
  logic [31:0]       icache_wdata;
  logic [31:0]       icache_rdata;
  logic [31:0]       icache_raddr;
  logic [8:0]        icache_rtag;
  logic              icache_rvalid;
  logic              error_overflow;

  always #5 clock = ~clock;

  cpu_icache_arbiter #(
    .NREQ        (2),
    .OUT_DEPTH   (4),
    .BURST_BEATS (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_request    (req_request),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_burst      (req_burst),
    .req_address    (req_address),
    .req_wstrb      (req_wstrb),
    .req_wdata      (req_wdata),
    .rsp_rvalid     (rsp_rvalid),
    .rsp_rdata      (rsp_rdata),
    .rsp_raddr      (rsp_raddr),
    .rsp_rtag       (rsp_rtag),
    .icache_request (icache_request),
    .icache_ready   (icache_ready),
    .icache_write   (icache_write),
    .icache_burst   (icache_burst),
    .icache_address (icache_address),
    .icache_wstrb   (icache_wstrb),
    .icache_wdata   (icache_wdata),
    .icache_rdata   (icache_rdata),
    .icache_raddr   (icache_raddr),
    .icache_rtag    (icache_rtag),
    .icache_rvalid  (icache_rvalid),
    .error_overflow (error_overflow)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  rq;
    logic [1:0]  wr;
    logic [1:0]  bu;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        rdy;
    logic        rv;
    logic [1:0]  e_ready;
    logic        e_ireq;
    logic [31:0] e_addr;
    logic [1:0]  e_rvalid;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(
    input string       nm,
    input logic        rst,
    input logic [1:0]  rq, wr, bu,
    input logic [31:0] a0, a1,
    input logic        rdy, rv,
    input logic [1:0]  er,
    input logic        ei,
    input logic [31:0] ea,
    input logic [1:0]  ev,
    input logic        eo
  );
    vec_t v;
    v.name = nm; v.rst = rst;
    v.rq = rq; v.wr = wr; v.bu = bu;
    v.a0 = a0; v.a1 = a1;
    v.rdy = rdy; v.rv = rv;
    v.e_ready = er; v.e_ireq = ei;
    v.e_addr = ea; v.e_rvalid = ev;
    v.e_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v, input int k);
    reset         = v.rst;
    req_request   = v.rq;
    req_write     = v.wr;
    req_burst     = v.bu;
    req_address   = {v.a1, v.a0};
    req_wstrb     = 8'hff;
    req_wdata     = {v.a1 ^ WK, v.a0 ^ WK};
    icache_ready  = v.rdy;
    icache_rvalid = v.rv;
    icache_rdata  = 32'hda7a_0000 | 32'(k);
    icache_raddr  = 32'h0;
    icache_rtag   = 9'(k);
  endtask

  task automatic check(input vec_t v, input int k);
    logic ok;
    ok = req_ready == v.e_ready &&
         icache_request == v.e_ireq &&
         (!v.e_ireq || icache_address == v.e_addr) &&
         rsp_rvalid == v.e_rvalid &&
         error_overflow == v.e_ovf &&
         rsp_rdata == (32'hda7a_0000 | 32'(k));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: ready=%b want %b ireq=%b want %b addr=%h want %h rvalid=%b want %b ovf=%b want %b rdata=%h",
               v.name, req_ready, v.e_ready, icache_request,
               v.e_ireq, icache_address, v.e_addr, rsp_rvalid,
               v.e_rvalid, error_overflow, v.e_ovf, rsp_rdata);
    end
  endtask

  initial begin
    logic got;
    //   name  rst rq wr bu a0 a1 rdy rv | ready ireq addr rvalid ovf
    add("reset",   1,2'b00,2'b00,2'b00,0,0,1,0, 2'b00,0,0,2'b00,0);
    add("rst_gate",1,2'b01,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b00,0);
    add("rd0",     0,2'b01,2'b00,2'b00,32'hffff0000,0,1,0,
        2'b01,1,32'hffff0000,2'b00,0);
    add("idle",    0,2'b00,2'b00,2'b00,0,0,1,0, 2'b00,0,0,2'b00,0);
    add("rsp0",    0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("alt_g1",  0,2'b11,2'b00,2'b00,32'h200,32'h300,1,0,
        2'b10,1,32'h300,2'b00,0);
    add("alt_g0",  0,2'b11,2'b00,2'b00,32'h200,32'h300,1,0,
        2'b01,1,32'h200,2'b00,0);
    add("alt_g1b", 0,2'b11,2'b00,2'b00,32'h200,32'h300,1,0,
        2'b10,1,32'h300,2'b00,0);
    add("alt_g0b", 0,2'b11,2'b00,2'b00,32'h200,32'h300,1,0,
        2'b01,1,32'h200,2'b00,0);
    add("full_pp", 0,2'b11,2'b00,2'b00,32'h200,32'h300,1,1,
        2'b10,1,32'h300,2'b10,0);
    add("rsp_a",   0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("rsp_b",   0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b10,0);
    add("rsp_c",   0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("rsp_d",   0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b10,0);
    add("ovf",     0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b00,1);
    add("ovf_end", 0,2'b00,2'b00,2'b00,0,0,1,0, 2'b00,0,0,2'b00,0);
    add("wr0",     0,2'b01,2'b01,2'b00,32'h40,0,1,0,
        2'b01,1,32'h40,2'b00,0);
    add("rd0_aw",  0,2'b01,2'b00,2'b00,32'h44,0,1,0,
        2'b01,1,32'h44,2'b00,0);
    add("rsp_aw",  0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("bst_b0",  0,2'b11,2'b10,2'b10,32'h200,32'h100,1,0,
        2'b10,1,32'h100,2'b00,0);
    add("bst_b1",  0,2'b11,2'b10,2'b00,32'h200,32'h104,1,0,
        2'b10,1,32'h104,2'b00,0);
    add("bst_hold",0,2'b01,2'b10,2'b00,32'h200,32'h108,1,0,
        2'b00,0,0,2'b00,0);
    add("bst_b2",  0,2'b11,2'b10,2'b00,32'h200,32'h108,1,0,
        2'b10,1,32'h108,2'b00,0);
    add("bst_b3",  0,2'b11,2'b10,2'b00,32'h200,32'h10c,1,0,
        2'b10,1,32'h10c,2'b00,0);
    add("bst_post",0,2'b11,2'b10,2'b00,32'h200,32'h110,1,0,
        2'b01,1,32'h200,2'b00,0);
    add("rsp_bst", 0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("fill1",   0,2'b01,2'b00,2'b00,32'h500,0,1,0,
        2'b01,1,32'h500,2'b00,0);
    add("fill2",   0,2'b01,2'b00,2'b00,32'h504,0,1,0,
        2'b01,1,32'h504,2'b00,0);
    add("fill3",   0,2'b01,2'b00,2'b00,32'h508,0,1,0,
        2'b01,1,32'h508,2'b00,0);
    add("fill4",   0,2'b01,2'b00,2'b00,32'h50c,0,1,0,
        2'b01,1,32'h50c,2'b00,0);
    add("fill5blk",0,2'b01,2'b00,2'b00,32'h510,0,1,0,
        2'b00,0,0,2'b00,0);
    add("fill5go", 0,2'b01,2'b00,2'b00,32'h510,0,1,1,
        2'b01,1,32'h510,2'b01,0);
    add("drain1",  0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("drain2",  0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("drain3",  0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("drain4",  0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("nrdy",    0,2'b01,2'b00,2'b00,32'h600,0,0,0,
        2'b00,1,32'h600,2'b00,0);
    add("nrdy_go", 0,2'b01,2'b00,2'b00,32'h600,0,1,0,
        2'b01,1,32'h600,2'b00,0);
    add("rb_b0",   0,2'b10,2'b10,2'b10,0,32'h700,1,0,
        2'b10,1,32'h700,2'b00,0);
    add("rb_b1",   0,2'b10,2'b10,2'b00,0,32'h704,1,0,
        2'b10,1,32'h704,2'b00,0);
    add("rb_rst",  1,2'b11,2'b10,2'b00,32'h800,32'h708,1,0,
        2'b00,0,0,2'b00,0);
    add("rb_idle", 0,2'b00,2'b00,2'b00,0,0,1,0, 2'b00,0,0,2'b00,0);
    add("rb_rr0",  0,2'b11,2'b10,2'b00,32'h800,32'h708,1,0,
        2'b01,1,32'h800,2'b00,0);
    add("rb_rsp",  0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b01,0);
    add("rb_empty",0,2'b00,2'b00,2'b00,0,0,1,1, 2'b00,0,0,2'b00,1);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k], k);
      @(negedge clock);
      check(vecs[k], k);
      @(posedge clock);
      #1;
    end

    // Requester 1 read with a bounded wait for its grant.
    req_request   = 2'b10;
    req_write     = 2'b00;
    req_burst     = 2'b00;
    req_address   = {32'h900, 32'h0};
    req_wdata     = {32'h900 ^ WK, WK};
    icache_ready  = 1'b1;
    icache_rvalid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (req_ready == 2'b10 && icache_address == 32'h900 &&
          icache_wdata == (32'h900 ^ WK) && !icache_write &&
          !icache_burst && icache_wstrb == 4'hf) begin
        got = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL hs_wait: ready=%b want 10 addr=%h want 00000900",
               req_ready, icache_address);
    end
    @(posedge clock);
    #1;
    req_request   = 2'b00;
    icache_rvalid = 1'b1;
    icache_rdata  = 32'hcafe_f00d;
    icache_raddr  = 32'h900;
    icache_rtag   = 9'h1a5;
    @(negedge clock);
    n_vec++;
    if (rsp_rvalid != 2'b10 || rsp_raddr != 32'h900 ||
        rsp_rtag != 9'h1a5 || rsp_rdata != 32'hcafe_f00d ||
        error_overflow) begin
      n_bad++;
      $display("FAIL rsp1: rvalid=%b want 10 raddr=%h want 900 tag=%h want 1a5 ovf=%b want 0",
               rsp_rvalid, rsp_raddr, rsp_rtag, error_overflow);
    end
    @(posedge clock);
    #1;
    icache_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
